// File: rtl/uart_pkg.sv
// uart_pkg
// Shared UART types and helpers, used by the receive and transmit paths.
//   rx_state_t    : receiver FSM states
//   parity_mode_t : parity configuration (NONE / EVEN / ODD)
//   ERR_*         : bit positions inside the 4-bit receive error vector
//   calc_parity   : expected parity bit of up to 9 data bits
//   vote3         : 2-of-3 majority used for bit sampling
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_mode_t;

    localparam int unsigned ERR_W       = 4;
    localparam int unsigned ERR_BREAK   = 0;
    localparam int unsigned ERR_PARITY  = 1;
    localparam int unsigned ERR_FRAME   = 2;
    localparam int unsigned ERR_OVERRUN = 3;

    // Unused upper bits must be zero-filled by the caller.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        calc_parity = (^data) ^ odd;
    endfunction

    function automatic logic vote3(input logic a, input logic b, input logic c);
        vote3 = (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
// Valid/ready word channel between the UART receiver and its consumer.
//   Rx_Valid_Out : word held on Rx_Data_Out / Rx_Error_Out
//   Rx_Ready_In  : consumer takes the word when high together with valid
//   Rx_Data_Out  : received data, DATA_BITS wide
//   Rx_Error_Out : [0] break, [1] parity, [2] frame, [3] overrun
// master = receiver side, slave = consumer side.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 Rx_Valid_Out;
    logic                 Rx_Ready_In;
    logic [DATA_BITS-1:0] Rx_Data_Out;
    logic [3:0]           Rx_Error_Out;

    modport master (
        output Rx_Valid_Out,
        output Rx_Data_Out,
        output Rx_Error_Out,
        input  Rx_Ready_In
    );

    modport slave (
        input  Rx_Valid_Out,
        input  Rx_Data_Out,
        input  Rx_Error_Out,
        output Rx_Ready_In
    );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Divides Clk down to a one-cycle oversampling tick.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   en         : count while high; counter is held at zero while low
//   clr        : restart the division period from zero
//   tick       : one-cycle pulse every DIV enabled cycles
module uart_baud_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Division counter, restarted on clr and parked while disabled.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || !en) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = en && !clr && (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Oversampling UART receiver: synchronises the line, validates the start
// bit, majority-votes every bit, checks parity/stop bits, detects breaks and
// presents each frame on a valid/ready output register with sticky overrun.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   Rx_In      : asynchronous serial line, idle high
//   rx_if      : master side of the word channel (valid/ready/data/error)
//   RTS        : receiver idle and output register free (registered)
//   Busy       : a frame is in progress (registered)
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 2,
    parameter int PARITY_MODE   = 1,
    parameter int MSB_FIRST     = 1,
    parameter int SYSCLOCK_FREQ = 100000000,
    parameter int BAUDRATE      = 9600,
    parameter int OVERSAMPLE    = 16
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           Rx_In,
    uart_rx_ctrl_if.master rx_if,
    output logic           RTS,
    output logic           Busy
);

    localparam int BAUD_DIV = SYSCLOCK_FREQ / (OVERSAMPLE * BAUDRATE);
    localparam int MID      = OVERSAMPLE / 2;
    localparam int TICK_W   = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(MID - 1);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(MID);
    localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(MID + 1);
    localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [1:0]        STOP_LAST = 2'(STOP_BITS - 1);
    localparam parity_mode_t      PAR_MODE  = parity_mode_t'(PARITY_MODE[1:0]);

    if (BAUD_DIV < 1) begin : g_bad_div
        $error("uart_rx_ctrl: SYSCLOCK_FREQ too low for BAUDRATE*OVERSAMPLE");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
        $error("uart_rx_ctrl: unsupported frame format");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_ctrl: OVERSAMPLE must be even and at least 8");
    end

    // Line synchroniser and edge history
    logic rx_meta_r;
    logic rxs_r;
    logic rxs_d_r;

    // Frame FSM and datapath
    rx_state_t            state_r;
    logic                 busy_r;
    logic [TICK_W-1:0]    tick_cnt_r;
    logic                 samp_a_r;
    logic                 samp_b_r;
    logic [3:0]           bit_cnt_r;
    logic [1:0]           stop_cnt_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 par_bit_r;
    logic                 frame_err_r;
    logic                 stop_one_r;

    // Output register
    logic                 valid_r;
    logic [DATA_BITS-1:0] data_out_r;
    logic [ERR_W-1:0]     err_out_r;
    logic                 rts_r;

    // Combinational helpers
    logic             baud_en_s;
    logic             baud_clr_s;
    logic             baud_tick_s;
    logic             start_fall_s;
    logic             vote_s;
    logic             bit_done_s;
    logic             frame_done_s;
    logic             frame_err_fin_s;
    logic             brk_s;
    logic             par_err_s;
    logic [ERR_W-1:0] err_new_s;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
            rxs_d_r   <= 1'b1;
        end else begin
            rx_meta_r <= Rx_In;
            rxs_r     <= rx_meta_r;
            rxs_d_r   <= rxs_r;
        end
    end

    assign start_fall_s = (state_r == IDLE) && rxs_d_r && !rxs_r;
    assign baud_en_s    = (state_r != IDLE);
    assign baud_clr_s   = start_fall_s;

    uart_baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_gen (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .en    (baud_en_s),
        .clr   (baud_clr_s),
        .tick  (baud_tick_s)
    );

    // Bit vote and end-of-frame classification (break wins over parity).
    always_comb begin
        vote_s          = vote3(samp_a_r, samp_b_r, rxs_r);
        bit_done_s      = baud_tick_s && (tick_cnt_r == TICK_S2);
        frame_done_s    = (state_r == STOP) && bit_done_s && (stop_cnt_r == STOP_LAST);
        frame_err_fin_s = frame_err_r | ~vote_s;
        brk_s           = (shreg_r == {DATA_BITS{1'b0}})
                          && ((PAR_MODE == NONE) || !par_bit_r)
                          && !stop_one_r && !vote_s;
        if (PAR_MODE != NONE) begin
            par_err_s = (calc_parity(9'(shreg_r), (PAR_MODE == ODD)) != par_bit_r) && !brk_s;
        end else begin
            par_err_s = 1'b0;
        end
        err_new_s              = 4'b0000;
        err_new_s[ERR_BREAK]   = brk_s;
        err_new_s[ERR_PARITY]  = par_err_s;
        err_new_s[ERR_FRAME]   = frame_err_fin_s | brk_s;
        err_new_s[ERR_OVERRUN] = 1'b0;
    end

    // Receive FSM: tick counting, sampling, shifting and frame sequencing.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            tick_cnt_r  <= {TICK_W{1'b0}};
            samp_a_r    <= 1'b1;
            samp_b_r    <= 1'b1;
            bit_cnt_r   <= 4'd0;
            stop_cnt_r  <= 2'd0;
            shreg_r     <= {DATA_BITS{1'b0}};
            par_bit_r   <= 1'b0;
            frame_err_r <= 1'b0;
            stop_one_r  <= 1'b0;
        end else begin
            if (baud_tick_s) begin
                if (tick_cnt_r == TICK_LAST) begin
                    tick_cnt_r <= {TICK_W{1'b0}};
                end else begin
                    tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                end
                if (tick_cnt_r == TICK_S0) begin
                    samp_a_r <= rxs_r;
                end
                if (tick_cnt_r == TICK_S1) begin
                    samp_b_r <= rxs_r;
                end
            end
            case (state_r)
                IDLE: begin
                    tick_cnt_r <= {TICK_W{1'b0}};
                    if (start_fall_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        if (vote_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= DATA;
                            bit_cnt_r <= 4'd0;
                        end
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        if (MSB_FIRST != 0) begin
                            shreg_r <= {shreg_r[DATA_BITS-2:0], vote_s};
                        end else begin
                            shreg_r <= {vote_s, shreg_r[DATA_BITS-1:1]};
                        end
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r     <= (PAR_MODE != NONE) ? PARITY : STOP;
                            stop_cnt_r  <= 2'd0;
                            frame_err_r <= 1'b0;
                            stop_one_r  <= 1'b0;
                            par_bit_r   <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done_s) begin
                        par_bit_r <= vote_s;
                        state_r   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        if (!vote_s) begin
                            frame_err_r <= 1'b1;
                        end
                        if (vote_s) begin
                            stop_one_r <= 1'b1;
                        end
                        // Finish at mid stop bit so the next start edge is caught.
                        if (stop_cnt_r == STOP_LAST) begin
                            if (brk_s) begin
                                state_r    <= BREAK_WAIT;
                                busy_r     <= 1'b1;
                                tick_cnt_r <= {TICK_W{1'b0}};
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            stop_cnt_r <= stop_cnt_r + 2'd1;
                        end
                    end
                end
                BREAK_WAIT: begin
                    // Need a full bit time of uninterrupted idle-high line.
                    if (!rxs_r) begin
                        tick_cnt_r <= {TICK_W{1'b0}};
                    end else if (baud_tick_s && (tick_cnt_r == TICK_LAST)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output word register with sticky overrun until the held word is taken.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_r    <= 1'b0;
            data_out_r <= {DATA_BITS{1'b0}};
            err_out_r  <= 4'b0000;
        end else if (frame_done_s && (!valid_r || rx_if.Rx_Ready_In)) begin
            valid_r    <= 1'b1;
            data_out_r <= shreg_r;
            err_out_r  <= err_new_s;
        end else if (frame_done_s) begin
            err_out_r[ERR_OVERRUN] <= 1'b1;
        end else if (valid_r && rx_if.Rx_Ready_In) begin
            valid_r                <= 1'b0;
            err_out_r[ERR_OVERRUN] <= 1'b0;
        end
    end

    // Ready-to-send flag: idle and the output register can take a word.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rts_r <= 1'b0;
        end else begin
            rts_r <= (state_r == IDLE) && (!valid_r || rx_if.Rx_Ready_In);
        end
    end

    assign rx_if.Rx_Valid_Out = valid_r;
    assign rx_if.Rx_Data_Out  = data_out_r;
    assign rx_if.Rx_Error_Out = err_out_r;
    assign RTS                = rts_r;
    assign Busy               = busy_r;

endmodule
